// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch for the 16-bit core. Holds the loadable
//            instruction memory and the PC, resolves JMP/JN/JR and halts on END.
// Options  : FETCH_RETIRE_CNT_EN adds the saturating retire_cnt_o counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int         PC_W   = 12,
   parameter int         MEM_AW = 8,
   parameter logic [3:0] OP_JMP = 4'h8,
   parameter logic [3:0] OP_JN  = 4'h9,
   parameter logic [3:0] OP_JR  = 4'hA,
   parameter logic [3:0] OP_END = 4'hF
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              ld_valid_i,
   input  logic [MEM_AW-1:0] ld_adr_i,
   input  logic [15:0]       ld_data_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flag_eq_i,
   output logic [15:0]       instr_o,
   output logic              instr_vld_o,
   output logic [PC_W-1:0]   pc_o,
   output logic              busy_o,
   output logic              halted_o
`ifdef FETCH_RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt_o
`endif
);

   localparam int              c_MEM_DEPTH = 2**MEM_AW;
   localparam logic [PC_W-1:0] c_PC_ONE    = PC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_mem [c_MEM_DEPTH];
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pc_o;
   logic [15:0]     r_instr;
   logic            r_vld;
   logic            r_halted;

   logic [3:0]      w_op;
   logic [PC_W-1:0] w_target;
   logic            w_stopped;
   logic            w_start;
   logic            w_ld_ok;
   logic            w_step;
   logic            w_adv;
   logic            w_end;
   logic            w_taken;

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op        = r_instr[15:12];
      w_target    = PC_W'(r_instr[11:0]);
      w_stopped   = (r_state == S_IDLE) || (r_state == S_HALT);
      w_start     = w_stopped && start_i;
      w_ld_ok     = w_stopped && ld_valid_i;
      w_step      = ((r_state == S_RUN) || (r_state == S_FLUSH)) && !stall_i;
      // A valid word is consumed by the decoder only on an unstalled cycle
      w_adv       = r_vld && !stall_i;
      w_end       = w_adv && (w_op == OP_END);
      w_taken     = w_adv && ((w_op == OP_JMP) ||
                              ((w_op == OP_JN) && !flag_eq_i) ||
                              ((w_op == OP_JR) &&  flag_eq_i));
      case (r_state)
         S_IDLE, S_HALT: begin
            if (start_i) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_end)        w_state_nxt = S_HALT;
            else if (w_taken) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (!stall_i) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_ld_ok) begin
         r_mem[ld_adr_i] <= ld_data_i;
      end
   end

   // instr_o is the read register of the memory; a taken jump squashes the word read alongside it
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_pc_o   <= '0;
         r_instr  <= '0;
         r_vld    <= 1'b0;
         r_halted <= 1'b0;
      end else if (w_start) begin
         r_pc     <= '0;
         r_halted <= 1'b0;
      end else if (w_end) begin
         r_vld    <= 1'b0;
         r_halted <= 1'b1;
      end else if (w_step) begin
         r_instr  <= r_mem[r_pc[MEM_AW-1:0]];
         r_pc_o   <= r_pc;
         r_vld    <= !w_taken;
         r_pc     <= w_taken ? w_target : r_pc + c_PC_ONE;
      end
   end

`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] r_retire_cnt;

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         r_retire_cnt <= '0;
      end else if (w_start) begin
         r_retire_cnt <= '0;
      end else if (w_adv && (r_retire_cnt != 16'hFFFF)) begin
         r_retire_cnt <= r_retire_cnt + 16'd1;
      end
   end

   assign retire_cnt_o = r_retire_cnt;
`endif

   assign instr_o     = r_instr;
   assign instr_vld_o = r_vld;
   assign pc_o        = r_pc_o;
   assign busy_o      = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign halted_o    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Bench for fetch_unit: a program-level trace model fills a scoreboard queue,
// a negedge monitor pops one entry per consumed instruction and checks timing.
module tb_fetch_unit;

   logic        clk_i      = 1'b0;
   logic        rst        = 1'b1;
   logic        ld_valid_i = 1'b0;
   logic [7:0]  ld_adr_i   = 8'd0;
   logic [15:0] ld_data_i  = 16'd0;
   logic        start_i    = 1'b0;
   logic        stall_i    = 1'b0;
   logic        flag_eq_i  = 1'b0;
   logic [15:0] instr_o;
   logic        instr_vld_o;
   logic [11:0] pc_o;
   logic        busy_o;
   logic        halted_o;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] retire_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [11:0] pc;
      logic [15:0] instr;
      int          gap;
      bit          is_end;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [15:0] img [256];
   int          trace_len;
   int          gap      = 0;
   bit          chk_halt = 1'b0;

   fetch_unit dut (
      .clk_i       (clk_i),
      .rst         (rst),
      .ld_valid_i  (ld_valid_i),
      .ld_adr_i    (ld_adr_i),
      .ld_data_i   (ld_data_i),
      .start_i     (start_i),
      .stall_i     (stall_i),
      .flag_eq_i   (flag_eq_i),
      .instr_o     (instr_o),
      .instr_vld_o (instr_vld_o),
      .pc_o        (pc_o),
      .busy_o      (busy_o),
      .halted_o    (halted_o)
`ifdef FETCH_RETIRE_CNT_EN
      ,
      .retire_cnt_o(retire_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Walks the program as the architecture defines it; gap is the number of
   // unstalled clocks between consecutive deliveries (2 after start or a taken jump).
   task automatic build_trace(input bit flag, input int max_items);
      int          pc;
      bit          taken;
      logic [15:0] w;
      logic [3:0]  op;
      exp_t        e;
      pc        = 0;
      taken     = 1'b1;
      trace_len = 0;
      for (int n = 0; n < max_items; n++) begin
         w        = img[pc % 256];
         op       = w[15:12];
         e.pc     = 12'(pc);
         e.instr  = w;
         e.gap    = taken ? 2 : 1;
         e.is_end = (op == 4'hF);
         q.push_back(e);
         trace_len++;
         if (e.is_end) break;
         taken = (op == 4'h8) || (op == 4'h9 && !flag) || (op == 4'hA && flag);
         pc    = taken ? int'(w[11:0]) : (pc + 1) % 4096;
      end
   endtask

   task automatic fill_img(input logic [15:0] v);
      for (int a = 0; a < 256; a++) img[a] = v;
   endtask

   // Loads the whole image; the final write (address 0) coincides with start_i.
   task automatic load_and_start();
      for (int i = 0; i < 256; i++) begin
         @(posedge clk_i); #1;
         ld_valid_i = 1'b1;
         ld_adr_i   = 8'((i + 1) % 256);
         ld_data_i  = img[(i + 1) % 256];
         start_i    = (i == 255);
      end
      @(posedge clk_i); #1;
      ld_valid_i = 1'b0;
      start_i    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_instr"},  32'(instr_o),     32'h0);
      chk({tag, "_vld"},    32'(instr_vld_o), 32'h0);
      chk({tag, "_pc"},     32'(pc_o),        32'h0);
      chk({tag, "_busy"},   32'(busy_o),      32'h0);
      chk({tag, "_halted"}, 32'(halted_o),    32'h0);
`ifdef FETCH_RETIRE_CNT_EN
      chk({tag, "_retire"}, 32'(retire_cnt_o), 32'h0);
`endif
   endtask

   task automatic run_prog(input bit flag, input int stall_pct, input int lo, input int hi,
                           input bit noise);
      bit done;
      flag_eq_i = flag;
      q.delete();
      build_trace(flag, 300);
      load_and_start();
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (halted_o) begin
            done       = 1'b1;
            stall_i    = 1'b0;
            ld_valid_i = 1'b0;
         end else begin
            stall_i    = (c >= lo && c <= hi) || (int'($urandom_range(99, 0)) < stall_pct);
            ld_valid_i = noise && ($urandom_range(2, 0) == 0);
            ld_adr_i   = $urandom_range(1, 0) ? 8'd2 : 8'($urandom);
            ld_data_i  = 16'hFFFF;
            @(posedge clk_i); #1;
         end
      end
      stall_i    = 1'b0;
      ld_valid_i = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL timeout: halted_o never rose, %0d entries left", q.size());
         #3 rst = 1'b1;
         @(posedge clk_i); #1 rst = 1'b0;
         q.delete();
      end else begin
         @(posedge clk_i); #1;
         @(posedge clk_i); #1;
         chk("drain", 32'(q.size()), 32'h0);
`ifdef FETCH_RETIRE_CNT_EN
         chk("retire_cnt", 32'(retire_cnt_o), 32'(trace_len));
`endif
      end
   endtask

   task automatic gen_random();
      int         n;
      int         r;
      logic [3:0] op;
      n = $urandom_range(30, 4);
      for (int a = 0; a < 256; a++) img[a] = 16'($urandom);
      for (int a = 0; a < n; a++) begin
         r = $urandom_range(9, 0);
         if (r < 3) begin
            op     = 4'h8 + 4'(r);
            img[a] = {op, 12'($urandom_range(n, a + 1))};
         end else begin
            r      = $urandom_range(11, 0);
            op     = (r < 8) ? 4'(r) : 4'(r + 3);
            img[a] = {op, 12'($urandom)};
         end
      end
      img[n] = {4'hF, 12'($urandom)};
   endtask

   always @(negedge clk_i) begin
      if (rst) begin
         gap      = 0;
         chk_halt = 1'b0;
      end else begin
         if (chk_halt) begin
            chk("halt_flag", 32'(halted_o),    32'h1);
            chk("halt_vld",  32'(instr_vld_o), 32'h0);
            chk("halt_busy", 32'(busy_o),      32'h0);
            chk_halt = 1'b0;
         end
         if (start_i && !busy_o) begin
            gap = 0;
         end else begin
            if (!stall_i) gap++;
            if (instr_vld_o) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_valid: pc_o=%0h instr_o=%0h, no entry expected",
                           pc_o, instr_o);
               end else if (stall_i) begin
                  chk("stall_pc",    32'(pc_o),    32'(q[0].pc));
                  chk("stall_instr", 32'(instr_o), 32'(q[0].instr));
               end else begin
                  mon_e = q.pop_front();
                  chk("pc",    32'(pc_o),              32'(mon_e.pc));
                  chk("instr", 32'(instr_o),           32'(mon_e.instr));
                  chk("gap",   32'(gap),               32'(mon_e.gap));
                  chk("state", 32'({halted_o, busy_o}), 32'h1);
                  gap      = 0;
                  chk_halt = mon_e.is_end;
               end
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // straight-line program, then again with a mid-program stall and ignored writes
      fill_img(16'h0000);
      img[0] = 16'h1123; img[1] = 16'h2045; img[2] = 16'h3001; img[3] = 16'hF000;
      run_prog(1'b0, 0, -1, -1, 1'b0);
      run_prog(1'b0, 0, 2, 4, 1'b1);

      // unconditional jump, free-running and stalled while the jump is valid
      fill_img(16'h0000);
      img[0] = 16'h8010; img[16] = 16'hF000;
      run_prog(1'b0, 0, -1, -1, 1'b0);
      run_prog(1'b0, 0, 1, 3, 1'b0);

      // conditional jumps, both flag senses
      fill_img(16'h0000);
      img[0] = 16'h9020; img[1] = 16'hF000; img[32] = 16'hF000;
      run_prog(1'b0, 0, -1, -1, 1'b0);
      run_prog(1'b1, 0, -1, -1, 1'b0);
      img[0] = 16'hA020;
      run_prog(1'b1, 0, -1, -1, 1'b0);
      run_prog(1'b0, 0, -1, -1, 1'b0);

      // endless loop across the PC wrap, cut by asynchronous reset, then restarted
      fill_img(16'h0000);
      img[0] = 16'h8FFF; img[255] = 16'h1234;
      flag_eq_i = 1'b0;
      q.delete();
      build_trace(1'b0, 40);
      load_and_start();
      repeat (20) @(posedge clk_i);
      #3 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      q.delete();
      @(posedge clk_i); #1 rst = 1'b0;
      build_trace(1'b0, 40);
      @(posedge clk_i); #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (12) @(posedge clk_i);
      chk("restart_progress", 32'(q.size() < 40), 32'h1);
      #3 rst = 1'b1;
      #1 check_reset_outputs("async_rst2");
      q.delete();
      @(posedge clk_i); #1 rst = 1'b0;

      repeat (12) begin
         gen_random();
         run_prog(1'($urandom_range(1, 0)), 25, -1, -1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the 16-bit core. It is the producer side of the decoder's instr_i interface.
- Holds a loadable instruction memory and the program counter.
- Presents one 16-bit instruction per cycle with a valid flag.
- Resolves JMP/JN/JR redirects and halts on END.
- Freezes while the downstream stage asserts stall.

Parameters:
PC_W, 12, program counter width (matches 12-bit jump target field instr[11:0])
MEM_AW, 8, instruction memory address width; depth 2**MEM_AW words; index is pc[MEM_AW-1:0]
OP_JMP, 4'h8, unconditional jump opcode
OP_JN, 4'h9, jump-if-not-equal opcode
OP_JR, 4'hA, jump-if-equal opcode
OP_END, 4'hF, end-of-program opcode

Ports:
clk_i  in  1  clock
rst  in  1  reset, asynchronous, active-high
ld_valid_i  in  1  memory load strobe
ld_adr_i  in  MEM_AW  load address
ld_data_i  in  16  load data
start_i  in  1  begin execution at address 0
stall_i  in  1  downstream hold
flag_eq_i  in  1  ALU equality flag used by JN/JR
instr_o  out  16  instruction to decoder
instr_vld_o  out  1  instr_o is valid
pc_o  out  PC_W  address of instr_o
busy_o  out  1  state is RUN or FLUSH
halted_o  out  1  END retired; cleared by start_i

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE, pc=0, instr_o=0, instr_vld_o=0, pc_o=0, busy_o=0, halted_o=0.
- Memory contents are not reset.

States: IDLE, RUN, FLUSH, HALT.

Memory:
- Synchronous write: on ld_valid_i, mem[ld_adr_i] <= ld_data_i, in IDLE or HALT only; ignored in RUN/FLUSH.
- Synchronous read of mem[pc], one-cycle latency.

IDLE/HALT:
- start_i: pc<=0, state<=RUN, halted_o<=0.
- If start_i and ld_valid_i are asserted in the same cycle, the write completes first; the new word is visible to the fetch.
- Otherwise outputs hold, with instr_vld_o=0.

RUN, stall_i=0, every cycle:
- instr_o<=mem[pc], pc_o<=pc, instr_vld_o<=1, pc<=pc+1.
- pc wraps modulo 2**PC_W.
- First valid instruction appears 2 cycles after start_i is sampled.

RUN, stall_i=1:
- pc, instr_o, pc_o and instr_vld_o all hold.
- No redirect or halt is evaluated; stall has priority over both.

Redirect, evaluated on the current instr_o when instr_vld_o=1 and stall_i=0 (op = instr_o[15:12]):
- Taken when op==OP_JMP, or op==OP_JN && flag_eq_i==0, or op==OP_JR && flag_eq_i==1.
- When taken: pc<=instr_o[11:0], state<=FLUSH. The word fetched that cycle is squashed: the next cycle's instr_vld_o=0.
- FLUSH lasts 1 cycle (fetch at target in progress), then RUN. Taken-jump penalty is 1 bubble.
- Not-taken JN/JR: no bubble.

END:
- When instr_o carries op==OP_END, instr_vld_o=1 and stall_i=0: state<=HALT, halted_o<=1, instr_vld_o<=0 next cycle.
- END is delivered to the decoder for exactly one valid cycle.

Other rules:
- busy_o is combinational from state.
- Reset mid-RUN returns to IDLE immediately; no partial instruction is ever left valid.
- start_i is ignored in RUN/FLUSH.

Optional Feature:
Macro FETCH_RETIRE_CNT_EN.
- Defined: adds output retire_cnt_o [15:0], reset 0. Increments on every cycle with instr_vld_o=1 and stall_i=0. Saturates at 16'hFFFF. Cleared on start_i.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load mem[0..3]={16'h1123,16'h2045,16'h3001,16'hF000}; pulse start_i -> instr_o sequence 1123,2045,3001,F000 on consecutive cycles with pc_o 0..3, first valid 2 cycles after start; then halted_o=1, instr_vld_o=0, busy_o=0.
- mem[0]=16'h8010 (JMP 0x010), mem[16]=16'hF000 -> 8010 valid, one bubble (instr_vld_o=0), then F000 with pc_o=0x010.
- mem[0]=16'h9020 (JN): with flag_eq_i=0, next valid pc_o=0x020 after 1 bubble; with flag_eq_i=1, next valid pc_o=1 with no bubble. Repeat for OP_JR (16'hA020) with inverted flag sense.
- Hold stall_i=1 for 3 cycles mid-program -> instr_o/pc_o/instr_vld_o frozen for 3 cycles; stall asserted on the cycle a JMP is valid delays the redirect until release.
- Assert rst asynchronously while in RUN -> all outputs 0 within the same cycle, state IDLE; a later start_i restarts from pc 0 with memory contents intact.
- ld_valid_i during RUN writing mem[2]=16'hFFFF -> ignored, original mem[2] is fetched. With FETCH_RETIRE_CNT_EN defined, the 4-instruction program ends with retire_cnt_o=4.
